// File: rtl/eka_dmem_responder.sv
// Data-memory responder for the single-cycle Eka core.
// Loads are served combinationally and stores commit on the next rising edge.
// After reset the array is cleared one word per cycle before the core may run.
// A loader port can preload words whenever the core is not storing.
module eka_dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   localparam int unsigned IW         = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   data_addr,
   input  logic [31:0]   mem_wr_data,
   input  logic          mem_wr,
   input  logic          mem_rd,
   output logic [31:0]   mem_rd_data,
   input  logic          load_valid,
   input  logic [IW-1:0] load_addr,
   input  logic [31:0]   load_data,
   output logic          load_ready,
   output logic          init_done,
   output logic          align_err,
   output logic          range_err,
   output logic [31:0]   rd_count,
   output logic [31:0]   wr_count
);

   // Byte span of the array, one bit wider so DEPTH_WORDS*4 never overflows.
   localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [IW-1:0] r_clr_idx;
   logic [31:0]   r_mem [DEPTH_WORDS];

   logic [31:0]   w_offset;
   logic          w_in_range;
   logic          w_aligned;
   logic [IW-1:0] w_word_idx;
   logic          w_run;
   logic          w_core_rd;
   logic          w_core_acc;
   logic          w_wr_commit;
   logic          w_load_fire;
   logic          w_we;
   logic [IW-1:0] w_waddr;
   logic [31:0]   w_wdata;

   // Address decode relative to the array base; a wrapped subtraction makes
   // addresses below BASE_ADDR land far out of range.
   assign w_offset    = data_addr - BASE_ADDR;
   assign w_in_range  = ({1'b0, w_offset} < SPAN_BYTES);
   assign w_aligned   = (data_addr[1:0] == 2'b00);
   assign w_word_idx  = w_offset[IW+1:2];

   assign w_run       = (r_state == ST_RUN);
   assign w_core_rd   = w_run & mem_rd & ~mem_wr;
   assign w_core_acc  = w_run & (mem_rd | mem_wr);
   assign w_wr_commit = w_run & mem_wr & w_in_range & w_aligned;

   // The core always wins the single write port, so the loader backs off.
   assign load_ready  = w_run & ~mem_wr;
   assign w_load_fire = load_valid & load_ready;
   assign init_done   = w_run;

   // State register.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_CLEAR;
      else       r_state <= w_state_nxt;
   end

   // Next state: leave CLEAR once the last word has been zeroed.
   // NOTE: every combinational output gets a default first so no path
   // leaves it unassigned and infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_CLEAR: if (&r_clr_idx) w_state_nxt = ST_RUN;
         ST_RUN:   w_state_nxt = ST_RUN;
         default:  w_state_nxt = ST_CLEAR;
      endcase
   end

   // Clear pointer walks the array once per reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  r_clr_idx <= '0;
      else if (r_state == ST_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
   end

   // Write-port arbitration: clear, then core store, then loader.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = '0;
      w_wdata = '0;
      if (!w_run) begin
         w_we    = 1'b1;
         w_waddr = r_clr_idx;
      end else if (w_wr_commit) begin
         w_we    = 1'b1;
         w_waddr = w_word_idx;
         w_wdata = mem_wr_data;
      end else if (w_load_fire) begin
         w_we    = 1'b1;
         w_waddr = load_addr;
         w_wdata = load_data;
      end
   end

   // Array write.
   // NOTE: the array has no reset term; the CLEAR walk zeroes it, which keeps
   // it mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end

   // Combinational load path; returns the pre-write word on a same-cycle store.
   always_comb begin
      mem_rd_data = '0;
      if (w_run && mem_rd && w_in_range) mem_rd_data = r_mem[w_word_idx];
   end

   // Sticky error flags for any core access in RUN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         align_err <= 1'b0;
         range_err <= 1'b0;
      end else if (w_core_acc) begin
         if (!w_aligned)  align_err <= 1'b1;
         if (!w_in_range) range_err <= 1'b1;
      end
   end

   // Access counters; both wrap naturally at 2^32.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (w_core_rd)   rd_count <= rd_count + 32'd1;
         if (w_wr_commit) wr_count <= wr_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_eka_dmem_responder.sv
// Scoreboarded bench for eka_dmem_responder with a 16-word array at 0x1000.
// Stimulus pushes expected load data; a negedge monitor pops and compares it.
module tb_eka_dmem_responder;

   localparam int          DW   = 16;
   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk;
   logic        reset;
   logic [31:0] data_addr;
   logic [31:0] mem_wr_data;
   logic        mem_wr;
   logic        mem_rd;
   logic [31:0] mem_rd_data;
   logic        load_valid;
   logic [3:0]  load_addr;
   logic [31:0] load_data;
   logic        load_ready;
   logic        init_done;
   logic        align_err;
   logic        range_err;
   logic [31:0] rd_count;
   logic [31:0] wr_count;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] sb [$];

   eka_dmem_responder #(
      .DEPTH_WORDS (DW),
      .BASE_ADDR   (BASE)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .data_addr   (data_addr),
      .mem_wr_data (mem_wr_data),
      .mem_wr      (mem_wr),
      .mem_rd      (mem_rd),
      .mem_rd_data (mem_rd_data),
      .load_valid  (load_valid),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .init_done   (init_done),
      .align_err   (align_err),
      .range_err   (range_err),
      .rd_count    (rd_count),
      .wr_count    (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: whenever the core presents a load, compare against the scoreboard.
   always @(negedge clk) begin
      if (mem_rd === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: got 0x%08h expected no load", mem_rd_data);
         end else begin
            check("rd_data", mem_rd_data, sb.pop_front());
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      load_valid = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      data_addr   = a;
      mem_wr_data = d;
      mem_wr      = 1'b1;
      cyc();
      mem_wr      = 1'b0;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] e);
      data_addr = a;
      mem_rd    = 1'b1;
      sb.push_back(e);
      cyc();
      mem_rd    = 1'b0;
   endtask

   // Count cycles until init_done; optionally hammer the core port meanwhile.
   task automatic wait_init(input bit poke, output int n);
      n = 0;
      while (init_done !== 1'b1 && n < 100) begin
         if (poke) begin
            data_addr   = n[0] ? BASE + 32'd8 : BASE - 32'd2;
            mem_wr_data = 32'hFFFF_FFFF;
            mem_rd      = 1'b1;
            mem_wr      = n[0];
            sb.push_back(32'h0);
         end
         cyc();
         n++;
      end
      idle();
   endtask

   task automatic check_status(input logic [31:0] rd, input logic [31:0] wr,
                               input logic ae, input logic re);
      check("rd_count", rd_count, rd);
      check("wr_count", wr_count, wr);
      check("align_err", {31'd0, align_err}, {31'd0, ae});
      check("range_err", {31'd0, range_err}, {31'd0, re});
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      reset       = 1'b1;
      data_addr   = '0;
      mem_wr_data = '0;
      load_addr   = '0;
      load_data   = '0;
      idle();
      repeat (3) cyc();

      // Reset state.
      check("rst_init_done", {31'd0, init_done}, 32'd0);
      check("rst_load_ready", {31'd0, load_ready}, 32'd0);
      check_status(0, 0, 1'b0, 1'b0);

      // Clear takes exactly DW cycles, then every word reads zero.
      reset = 1'b0;
      wait_init(1'b0, n);
      check("clear_cycles", 32'(n), 32'd16);
      check("run_load_ready", {31'd0, load_ready}, 32'd1);
      for (int i = 0; i < DW; i++) load(BASE + 32'(4 * i), 32'h0);
      check_status(16, 0, 1'b0, 1'b0);

      // Store then load back.
      store(BASE + 32'd8, 32'hDEAD_BEEF);
      load(BASE + 32'd8, 32'hDEAD_BEEF);
      check_status(17, 1, 1'b0, 1'b0);

      // Misaligned store dropped; misaligned load returns the aligned word.
      store(BASE + 32'd4, 32'h1111_1111);
      store(BASE + 32'd6, 32'h1234_5678);
      check_status(17, 2, 1'b1, 1'b0);
      load(BASE + 32'd6, 32'h1111_1111);
      load(BASE + 32'd8, 32'hDEAD_BEEF);

      // Out of range above and below; last word is in range.
      load(BASE + 32'd64, 32'h0);
      check_status(20, 2, 1'b1, 1'b1);
      store(BASE + 32'd64, 32'hBAD0_BAD0);
      load(BASE, 32'h0);
      store(BASE + 32'd60, 32'hCAFE_F00D);
      load(BASE + 32'd60, 32'hCAFE_F00D);
      load(BASE - 32'd4, 32'h0);
      check_status(23, 3, 1'b1, 1'b1);

      // No load request means zero data.
      data_addr = BASE + 32'd60;
      #1;
      check("idle_rd_data", mem_rd_data, 32'h0);

      // Core store and loader collide; core wins, loader lands next cycle.
      data_addr   = BASE + 32'd8;
      mem_wr_data = 32'h0102_0304;
      mem_wr      = 1'b1;
      load_valid  = 1'b1;
      load_addr   = 4'd3;
      load_data   = 32'h5A5A_5A5A;
      #1;
      check("collide_load_ready", {31'd0, load_ready}, 32'd0);
      cyc();
      mem_wr = 1'b0;
      #1;
      check("free_load_ready", {31'd0, load_ready}, 32'd1);
      cyc();
      idle();
      load(BASE + 32'd12, 32'h5A5A_5A5A);
      load(BASE + 32'd8, 32'h0102_0304);
      check_status(25, 4, 1'b1, 1'b1);

      // Read+write together: store semantics, old data visible, no rd count.
      data_addr   = BASE + 32'd12;
      mem_wr_data = 32'h7777_7777;
      mem_rd      = 1'b1;
      mem_wr      = 1'b1;
      sb.push_back(32'h5A5A_5A5A);
      cyc();
      idle();
      check_status(25, 5, 1'b1, 1'b1);
      load(BASE + 32'd12, 32'h7777_7777);

      // Reset mid-clear at index 5 restarts the full clear.
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      repeat (5) cyc();
      reset = 1'b1;
      #1;
      check("midclr_init_done", {31'd0, init_done}, 32'd0);
      check("midclr_load_ready", {31'd0, load_ready}, 32'd0);
      check_status(0, 0, 1'b0, 1'b0);
      cyc();
      reset = 1'b0;
      wait_init(1'b1, n);
      check("reclear_cycles", 32'(n), 32'd16);
      check_status(0, 0, 1'b0, 1'b0);
      load(BASE + 32'd8, 32'h0);
      load(BASE + 32'd12, 32'h0);
      load(BASE + 32'd60, 32'h0);
      check_status(3, 0, 1'b0, 1'b0);

      cyc();
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
